// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES CTR-mode sequencers: block/key widths,
// default counter width and the controller state encoding.
package aes_ctr_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES192_KEY_W  = 192;
  localparam int CTR_WIDTH_DEF = 32;

  typedef logic [2:0] ctr_state_t;

  localparam ctr_state_t ST_IDLE      = 3'd0;
  localparam ctr_state_t ST_START     = 3'd1;
  localparam ctr_state_t ST_WAIT_ACK  = 3'd2;
  localparam ctr_state_t ST_WAIT_DONE = 3'd3;
  localparam ctr_state_t ST_OUT       = 3'd4;

endpackage

// File: rtl/aes_ctr_incr.sv
// Combinational CTR-block increment: bumps only the low CTR_WIDTH bits,
// leaves the nonce untouched and flags when the low field rolls over.
module aes_ctr_incr
  import aes_ctr_pkg::*;
#(
  parameter int BLK_W     = AES_BLK_W,
  parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
  input  logic [BLK_W-1:0] blk_i,
  output logic [BLK_W-1:0] blk_o,
  output logic             wrap_o
);

  logic [CTR_WIDTH-1:0] low;

  assign low    = blk_i[CTR_WIDTH-1:0];
  assign wrap_o = &low;

  generate
    if (CTR_WIDTH < BLK_W) begin : g_nonce
      assign blk_o = {blk_i[BLK_W-1:CTR_WIDTH], low + CTR_WIDTH'(1)};
    end else begin : g_full
      assign blk_o = low + CTR_WIDTH'(1);
    end
  endgenerate

endmodule

// File: rtl/aes_192_ctr_ctrl.sv
// CTR-mode sequencer for aes_192_sed: one start pulse per block, result on a
// valid/ready port. Define AES_CTR_TIMEOUT_EN to enable the wait-state abort.
module aes_192_ctr_ctrl
  import aes_ctr_pkg::*;
#(
  parameter int CTR_WIDTH      = CTR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_load,
  input  logic [AES192_KEY_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0]    cfg_iv,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AES_BLK_W-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AES_BLK_W-1:0]    out_data,
  output logic                    busy,
  output logic                    ctr_wrap,
  output logic                    timeout_err,
  output logic                    aes_start,
  output logic [AES_BLK_W-1:0]    aes_state,
  output logic [AES_BLK_W-1:0]    aes_p_c_text,
  output logic [AES192_KEY_W-1:0] aes_key,
  input  logic [AES_BLK_W-1:0]    aes_out,
  input  logic                    aes_out_valid
);

  ctr_state_t              state_q, state_d;
  logic [AES192_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0]    ctr_q, ctr_d;
  logic [AES_BLK_W-1:0]    blk_q, blk_d;
  logic [AES_BLK_W-1:0]    res_q, res_d;
  logic                    wrap_q, wrap_d;
  logic [AES_BLK_W-1:0]    ctr_inc;
  logic                    ctr_inc_wrap;
  logic                    terr;
  logic                    accept;

  aes_ctr_incr #(
    .BLK_W    (AES_BLK_W),
    .CTR_WIDTH(CTR_WIDTH)
  ) u_incr (
    .blk_i (ctr_q),
    .blk_o (ctr_inc),
    .wrap_o(ctr_inc_wrap)
  );

`ifdef AES_CTR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             terr_q, terr_d;
  assign terr = terr_q;
`else
  assign terr = 1'b0;
`endif

  // Reset term keeps in_ready low while rst_n is held, not just after release.
  assign in_ready = rst_n && (state_q == ST_IDLE) && !wrap_q && !terr;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    blk_d   = blk_q;
    res_d   = res_q;
    wrap_d  = wrap_q;
`ifdef AES_CTR_TIMEOUT_EN
    terr_d  = terr_q;
    tmo_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          key_d  = cfg_key;
          ctr_d  = cfg_iv;
          wrap_d = 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
          terr_d = 1'b0;
`endif
        end
        if (accept) begin
          blk_d   = in_data;
          state_d = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_ACK;
      // The core's valid from the previous block must drop before a new one counts.
      ST_WAIT_ACK: begin
        if (!aes_out_valid) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (aes_out_valid) begin
          res_d   = aes_out;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          ctr_d   = ctr_inc;
          wrap_d  = wrap_q | ctr_inc_wrap;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AES_CTR_TIMEOUT_EN
    if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1) && state_d != ST_OUT) begin
        state_d = ST_IDLE;
        terr_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
      tmo_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      wrap_q  <= wrap_d;
`ifdef AES_CTR_TIMEOUT_EN
      tmo_q   <= tmo_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign out_valid    = (state_q == ST_OUT);
  assign out_data     = res_q;
  assign busy         = (state_q != ST_IDLE);
  assign ctr_wrap     = wrap_q;
  assign timeout_err  = terr;
  assign aes_start    = (state_q == ST_START) || (state_q == ST_WAIT_ACK) ||
                        (state_q == ST_WAIT_DONE);
  assign aes_state    = ctr_q;
  assign aes_p_c_text = blk_q;
  assign aes_key      = key_q;

endmodule

// File: tb/tb_aes_192_ctr_ctrl.sv
// Bench for aes_192_ctr_ctrl: behavioural AES-192 core model, CTR reference
// model feeding a scoreboard, and a decoupled output monitor.
`timescale 1ns/1ps
module tb_aes_192_ctr_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [191:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy, ctr_wrap, timeout_err, aes_start;
  logic [127:0] aes_state, aes_p_c_text;
  logic [191:0] aes_key;
  logic [127:0] core_out = '0;
  logic         core_vld = 1'b0;

  int checks = 0;
  int failures = 0;

  aes_192_ctr_ctrl #(.CTR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ctr_wrap(ctr_wrap), .timeout_err(timeout_err),
    .aes_start(aes_start), .aes_state(aes_state), .aes_p_c_text(aes_p_c_text),
    .aes_key(aes_key), .aes_out(core_out), .aes_out_valid(core_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // ---------------- AES-192 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) begin
          yb = 8'(y);
          if (gmul(xb, yb) == 8'h01) inv = yb;
        end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes192_enc(input logic [191:0] key, input logic [127:0] pt);
    logic [31:0]  w [52];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int rd = 0; rd <= 12; rd++) begin
      if (rd > 0) begin
        for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) n[4*c+rw] = s[4*((c+rw)%4)+rw];
        for (int k = 0; k < 16; k++) s[k] = n[k];
        if (rd < 12)
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = s[4*c+rw] ^ w[4*rd+c][31-8*rw -: 8];
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  // ---------------- core model (aes_192_sed behaviour) ----------------
  logic         start_prev = 1'b0;
  logic         core_run = 1'b0;
  int           core_cnt = 0;
  logic [127:0] c_st = '0, c_pt = '0;
  logic [191:0] c_key = '0;
  int           lat_min = 1, lat_max = 6;
  bit           core_dead = 1'b0;

  always @(posedge clk) begin
    start_prev <= aes_start;
    if (aes_start && !start_prev) begin
      core_vld <= 1'b0;
      core_run <= 1'b1;
      core_cnt <= $urandom_range(lat_max, lat_min);
      c_st     <= aes_state;
      c_pt     <= aes_p_c_text;
      c_key    <= aes_key;
    end else if (core_run && !core_dead) begin
      if (core_cnt == 0) begin
        core_vld <= 1'b1;
        core_out <= aes192_enc(c_key, c_st) ^ c_pt;
        core_run <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // ---------------- CTR reference model + scoreboard ----------------
  logic [191:0] m_key = '0;
  logic [127:0] m_ctr = '0;
  bit           m_wrap = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] cap_q[$];
  int           rdy_mode = 2;

  task automatic model_block(input logic [127:0] d);
    longint unsigned low;
    exp_q.push_back(d ^ aes192_enc(m_key, m_ctr));
    low = longint'(m_ctr[31:0]) + 1;
    if (low == 64'h1_0000_0000) m_wrap = 1'b1;
    m_ctr[31:0] = 32'(low % 64'h1_0000_0000);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output act=%h req=none", out_data);
      end else begin
        chk("out_data", {64'h0, out_data}, {64'h0, exp_q.pop_front()});
      end
      cap_q.push_back(out_data);
    end
  end

  // aes_start must sit low for at least two cycles before every rise
  bit aes_start_prev_n = 1'b0;
  int low_cnt = 100;
  always @(negedge clk) begin
    if (aes_start && !aes_start_prev_n) chk("start_gap", {191'h0, low_cnt >= 2}, 192'h1);
    low_cnt          = aes_start ? 0 : low_cnt + 1;
    aes_start_prev_n = aes_start;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL wait_idle act=busy req=idle");
    end
  endtask

  task automatic do_cfg(input logic [191:0] k, input logic [127:0] iv);
    wait_idle();
    @(posedge clk); #1;
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    m_key = k; m_ctr = iv; m_wrap = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept act=in_ready_low req=accepted");
      in_valid = 1'b0;
      return;
    end
    model_block(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cfg_blk(input logic [191:0] k, input logic [127:0] iv, input logic [127:0] d);
    wait_idle();
    @(posedge clk); #1;
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv; in_valid = 1'b1; in_data = d;
    @(negedge clk);
    chk("cfg_same_cycle_ready", {191'h0, in_ready}, 192'h1);
    m_key = k; m_ctr = iv; m_wrap = 1'b0;
    model_block(d);
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  logic [127:0] pts [4];
  logic [127:0] cts [4];
  logic [127:0] snap, ctr_before, iv;
  logic [191:0] k;
  int           n;

  initial begin
    build_sbox();
    #23;
    chk("rst_in_ready", {191'h0, in_ready}, 192'h0);
    chk("rst_out_valid", {191'h0, out_valid}, 192'h0);
    chk("rst_aes_start", {191'h0, aes_start}, 192'h0);
    chk("rst_flags", {189'h0, busy, ctr_wrap, timeout_err}, 192'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {191'h0, in_ready}, 192'h1);

    // FIPS-197 AES-192 vector through CTR with zero plaintext
    rdy_mode = 2;
    do_cfg(192'h000102030405060708090a0b0c0d0e0f1011121314151617,
           128'h00112233445566778899aabbccddeeff);
    send_block(128'h0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("fips_out", {64'h0, out_data}, {64'h0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191});
    wait_idle();
    chk("fips_ctr_low", {160'h0, aes_state[31:0]}, {160'h0, 32'hccddef00});
    chk("fips_ctr_high", {96'h0, aes_state[127:32]}, {96'h0, 96'h00112233445566778899aabb});

    // Round trip with random backpressure
    rdy_mode = 0;
    k = {rnd128(), $urandom, $urandom}; iv = rnd128();
    do_cfg(k, iv);
    cap_q.delete();
    for (int i = 0; i < 4; i++) begin pts[i] = rnd128(); send_block(pts[i]); end
    wait_idle();
    chk("rt_count1", {160'h0, 32'(cap_q.size())}, 192'd4);
    for (int i = 0; i < 4; i++) cts[i] = (i < cap_q.size()) ? cap_q[i] : '0;
    do_cfg(k, iv);
    cap_q.delete();
    for (int i = 0; i < 4; i++) send_block(cts[i]);
    wait_idle();
    chk("rt_count2", {160'h0, 32'(cap_q.size())}, 192'd4);
    for (int i = 0; i < 4; i++)
      chk("rt_plain", {64'h0, (i < cap_q.size()) ? cap_q[i] : 128'h0}, {64'h0, pts[i]});

    // Counter wrap
    rdy_mode = 2;
    iv = {rnd128() >> 32, 32'hffffffff};
    do_cfg({rnd128(), $urandom, $urandom}, iv);
    send_block(rnd128());
    wait_idle();
    chk("wrap_low", {160'h0, aes_state[31:0]}, 192'h0);
    chk("wrap_high", {96'h0, aes_state[127:32]}, {96'h0, iv[127:32]});
    chk("wrap_flag", {191'h0, ctr_wrap}, {191'h0, m_wrap});
    @(posedge clk); #1; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("wrap_in_ready", {190'h0, in_ready, busy}, 192'h0);
    @(posedge clk); #1; in_valid = 1'b0;
    do_cfg(aes_key, rnd128());
    @(negedge clk);
    chk("wrap_cleared", {190'h0, ctr_wrap, in_ready}, 192'h1);

    // Output backpressure with an ignored cfg_load during the stall
    rdy_mode = 1;
    ctr_before = m_ctr;
    send_block(rnd128());
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      chk("bp_stable", {62'h0, out_valid, in_ready, out_data}, {62'h0, 2'b10, snap});
      if (i == 3) begin cfg_load = 1'b1; cfg_key = ~m_key; cfg_iv = rnd128(); end
      if (i == 4) cfg_load = 1'b0;
      @(negedge clk);
    end
    chk("bp_key_kept", aes_key, m_key);
    chk("bp_ctr_kept", {64'h0, aes_state}, {64'h0, ctr_before});
    rdy_mode = 2;
    wait_idle();

    // Asynchronous reset while waiting on the core
    lat_min = 15; lat_max = 15;
    send_block(rnd128());
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {189'h0, out_valid, aes_start, busy}, 192'h0);
    chk("arst_in_ready", {191'h0, in_ready}, 192'h0);
    chk("arst_key", aes_key, 192'h0);
    void'(exp_q.pop_back());
    m_key = '0; m_ctr = '0; m_wrap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 6;
    do_cfg({rnd128(), $urandom, $urandom}, rnd128());
    cap_q.delete();
    send_block(rnd128());
    wait_idle();
    chk("arst_next_done", {160'h0, 32'(cap_q.size())}, 192'd1);

    // Random streams, including cfg_load coinciding with in_valid
    rdy_mode = 0;
    for (int r = 0; r < 3; r++) begin
      send_cfg_blk({rnd128(), $urandom, $urandom}, rnd128(), rnd128());
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
        lat_max = $urandom_range(1, 10);
        send_block(rnd128());
      end
      wait_idle();
      chk("stream_ctr", {64'h0, aes_state}, {64'h0, m_ctr});
    end
    lat_min = 1; lat_max = 6;

`ifdef AES_CTR_TIMEOUT_EN
    rdy_mode = 2;
    core_dead = 1'b1;
    ctr_before = m_ctr;
    send_block(rnd128());
    void'(exp_q.pop_back());
    m_ctr = ctr_before;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("tmo_no_out", {191'h0, out_valid}, 192'h0);
    end
    chk("tmo_err", {190'h0, timeout_err, busy}, 192'h2);
    chk("tmo_ctr", {64'h0, aes_state}, {64'h0, ctr_before});
    core_dead = 1'b0;
    do_cfg(aes_key, ctr_before);
    @(negedge clk);
    chk("tmo_cleared", {191'h0, timeout_err}, 192'h0);
`else
    chk("timeout_tied", {191'h0, timeout_err}, 192'h0);
`endif

    wait_idle();
    chk("scoreboard_empty", {160'h0, 32'(exp_q.size())}, 192'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
